// File: rtl/message_sound_player.sv
`default_nettype none
// ============================================================================
//  Module      : message_sound_player
//  Description : Notification-sound engine. Plays a PCM clip from an external
//                synchronous sample ROM on a receive-character match or an
//                explicit play request. It provides volume attenuation, mute,
//                a busy flag and a one-deep request queue or immediate restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module message_sound_player #(
   parameter int         SAMPLE_DIV = 9072,
   parameter int         ADDR_W     = 12,
   parameter int         DATA_W     = 16,
   parameter int         CLIP_W     = 1,
   parameter logic [7:0] RX_CHAR    = 8'h0A,
   parameter bit         RETRIGGER  = 1'b0
) (
   input  logic                     FPGA_clock,
   input  logic                     reset,
   input  logic [7:0]               text_rx,
   input  logic                     text_ready_rx,
   input  logic                     play_req,
   input  logic [CLIP_W-1:0]        play_sel,
   input  logic [1:0]               vol,
   input  logic                     mute,
   output logic [CLIP_W+ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic [DATA_W-1:0]        audio_out,
   output logic                     busy
);

   localparam int                DIV_W    = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [ADDR_W-1:0] OFF_LAST = '1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } state_t;

   state_t             state_q;
   logic [DIV_W-1:0]   div_q;
   logic [ADDR_W-1:0]  offset_q;
   logic [CLIP_W-1:0]  clip_q;
   logic               pend_v_q;
   logic [CLIP_W-1:0]  pend_clip_q;
   logic               rx_hit_q;
   logic               play_req_q;
   logic [DATA_W-1:0]  audio_q;
   logic               busy_q;

   logic               rx_hit;
   logic               rx_trig;
   logic               pr_trig;
   logic               any_trig;
   logic               both_trig;
   logic [CLIP_W-1:0]  first_clip;
   logic [CLIP_W-1:0]  newest_clip;
   logic               div_tc;
   logic               clip_end;
   logic signed [DATA_W-1:0] sample_att;
   logic [DATA_W-1:0]  audio_d;

   assign rx_hit      = text_ready_rx & (text_rx == RX_CHAR);
   assign rx_trig     = rx_hit & ~rx_hit_q;
   assign pr_trig     = play_req & ~play_req_q;
   assign any_trig    = rx_trig | pr_trig;
   assign both_trig   = rx_trig & pr_trig;
   // rx is the primary trigger; when both fire, play_req is the later request
   assign first_clip  = rx_trig ? '0 : play_sel;
   assign newest_clip = pr_trig ? play_sel : '0;
   assign div_tc      = (div_q == DIV_LAST);
   assign clip_end    = div_tc & (offset_q == OFF_LAST);
   assign sample_att  = $signed(rom_data) >>> vol;
   assign audio_d     = mute ? '0 : sample_att;

   assign rom_addr  = {clip_q, offset_q};
   assign audio_out = audio_q;
   assign busy      = busy_q;

   // Playback sequencer: trigger detection, sample pacing, queue and audio register
   always_ff @(posedge FPGA_clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         offset_q    <= '0;
         clip_q      <= '0;
         pend_v_q    <= 1'b0;
         pend_clip_q <= '0;
         rx_hit_q    <= 1'b0;
         play_req_q  <= 1'b0;
         audio_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         rx_hit_q   <= rx_hit;
         play_req_q <= play_req;
         case (state_q)
            S_IDLE: begin
               audio_q <= '0;
               if (any_trig) begin
                  state_q  <= S_PLAY;
                  busy_q   <= 1'b1;
                  div_q    <= '0;
                  offset_q <= '0;
                  // A simultaneous play_req acts as a second request on a busy engine
                  if (both_trig && RETRIGGER) begin
                     clip_q <= play_sel;
                  end else begin
                     clip_q <= first_clip;
                  end
                  if (both_trig && !RETRIGGER) begin
                     pend_v_q    <= 1'b1;
                     pend_clip_q <= play_sel;
                  end
               end
            end
            S_PLAY: begin
               audio_q <= audio_d;
               div_q   <= div_tc ? '0 : div_q + DIV_W'(1);
               if (any_trig && RETRIGGER) begin
                  clip_q   <= newest_clip;
                  offset_q <= '0;
                  div_q    <= '0;
               end else if (clip_end) begin
                  if (any_trig) begin
                     // Fresh request on the last tick supersedes any older pending one
                     clip_q   <= newest_clip;
                     offset_q <= '0;
                     pend_v_q <= 1'b0;
                  end else if (pend_v_q) begin
                     clip_q   <= pend_clip_q;
                     offset_q <= '0;
                     pend_v_q <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     audio_q <= '0;
                  end
               end else begin
                  if (div_tc) begin
                     offset_q <= offset_q + ADDR_W'(1);
                  end
                  if (any_trig) begin
                     pend_v_q    <= 1'b1;
                     pend_clip_q <= newest_clip;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
